// File: rtl/delay_prog_line.sv
// delay_prog_line
//   Clocked, programmable request delay line. Each request event seen on inR
//   is held in a small FIFO of down-counters, loaded with the delay programme
//   dly at the moment the event is detected. The event is reproduced on outR
//   once its counter has run down and it has reached the head of the queue.
//   Up to DEPTH events may be outstanding at the same time.
//
//   Parameters
//     CNT_W  : width of dly and of every per-entry down-counter
//     DEPTH  : maximum outstanding events (power of two, >= 2)
//     PHASE2 : 1 = two-phase (every inR toggle is an event, outR toggles)
//              0 = four-phase (inR rising edge is an event, outR pulses high
//                  for one cycle)
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous, active-low reset
//     inR  : request input, already synchronous to clk
//     dly  : delay programme, sampled on the edge where an event is detected
//     outR : delayed request output (registered)
//     busy : high while at least one event is held (registered)
//     ovf  : sticky flag, an event was dropped because the queue was full

module delay_prog_line #(
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4,
  parameter bit PHASE2 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inR,
  input  logic [CNT_W-1:0] dly,
  output logic             outR,
  output logic             busy,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

  logic [CNT_W-1:0] cnt [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   occ;
  logic [PTR_W:0]   occ_next;
  logic             inR_q;

  logic             evt;
  logic             pop;
  logic             push;
  logic             drop;
  logic [DEPTH-1:0] occupied;

  // Event detection, pop/push decisions and next occupancy.
  // A push into a full queue is accepted only when the head leaves on the
  // same edge; otherwise the event is lost and flagged through ovf.
  always_comb begin
    evt      = PHASE2 ? (inR ^ inR_q) : (inR & ~inR_q);
    pop      = (occ != '0) && (cnt[head] == '0);
    push     = evt && ((occ != OCC_FULL) || pop);
    drop     = evt && (occ == OCC_FULL) && !pop;
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // An entry is live when its distance from the head (modulo DEPTH) is
  // below the occupancy; only live entries count down.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = {1'b0, PTR_W'(i) - head} < occ;
    end
  end

  // Queue state, counters and registered outputs.
  // A freshly pushed tail entry takes dly and does not decrement on the push
  // edge, which gives the k+1+dly latency. When full with a simultaneous pop,
  // tail equals head and the write replaces the departing entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      inR_q <= 1'b0;
      outR  <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      inR_q <= inR;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail == PTR_W'(i))) begin
          cnt[i] <= dly;
        end else if (occupied[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      occ  <= occ_next;
      busy <= (occ_next != '0);
      if (drop) begin
        ovf <= 1'b1;
      end
      if (PHASE2) begin
        outR <= pop ? ~outR : outR;
      end else begin
        outR <= pop;
      end
    end
  end

endmodule

// File: tb/tb_delay_prog_line.sv
// tb_delay_prog_line
//   Directed bench for delay_prog_line. Two instances share clock, reset and
//   dly: u_two runs in two-phase mode, u_four in four-phase mode. Inputs are
//   changed 1 ns after a rising edge and outputs are sampled at the same
//   point, so after tick() returns the outputs reflect the edge just taken.
//   Edge numbers in the scenarios count from 1 after reset release.

module tb_delay_prog_line;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_two;
  logic       in_four;
  logic [7:0] dly;
  logic       out_two, busy_two, ovf_two;
  logic       out_four, busy_four, ovf_four;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  delay_prog_line #(.CNT_W(8), .DEPTH(4), .PHASE2(1'b1)) u_two (
    .clk(clk), .rst(rst), .inR(in_two), .dly(dly),
    .outR(out_two), .busy(busy_two), .ovf(ovf_two)
  );

  delay_prog_line #(.CNT_W(8), .DEPTH(4), .PHASE2(1'b0)) u_four (
    .clk(clk), .rst(rst), .inR(in_four), .dly(dly),
    .outR(out_four), .busy(busy_four), .ovf(ovf_four)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with idle inputs, release away from the edge.
  task automatic do_reset;
    rst     = 1'b0;
    in_two  = 1'b0;
    in_four = 1'b0;
    dly     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    in_two  = 1'b0;
    in_four = 1'b0;
    dly     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_two, busy_two, ovf_two, out_four, busy_four, ovf_four} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b expected 000000",
               {out_two, busy_two, ovf_two, out_four, busy_four, ovf_four});
    end
    rst = 1'b1;
  endtask

  // Event at edge 10 with dly=3 emerges at edge 14.
  task automatic test_latency;
    do_reset();
    repeat (9) tick();
    dly    = 8'd3;
    in_two = 1'b1;
    tick();
    for (int e = 10; e <= 15; e++) begin
      checks++;
      if (out_two !== (e >= 14)) begin
        fails++;
        $display("[TB] FAIL latency_out edge %0d: got %b expected %b", e, out_two, (e >= 14));
      end
      checks++;
      if (busy_two !== (e <= 13)) begin
        fails++;
        $display("[TB] FAIL latency_busy edge %0d: got %b expected %b", e, busy_two, (e <= 13));
      end
      tick();
    end
  endtask

  // dly=0 events on edges 5,6,7 toggle outR on edges 6,7,8.
  task automatic test_zero_delay;
    logic exp_out;
    do_reset();
    repeat (4) tick();
    dly = 8'd0;
    for (int e = 5; e <= 8; e++) begin
      if (e <= 7) in_two = ~in_two;
      tick();
      exp_out = (e >= 6) ^ (e >= 7) ^ (e >= 8);
      checks++;
      if (out_two !== exp_out) begin
        fails++;
        $display("[TB] FAIL zero_delay_out edge %0d: got %b expected %b", e, out_two, exp_out);
      end
    end
    checks++;
    if (ovf_two !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_delay_ovf: got %b expected 0", ovf_two);
    end
  endtask

  // Five events with dly=20 into a depth-4 queue: the fifth is dropped.
  task automatic test_overflow;
    int n;
    do_reset();
    dly = 8'd20;
    for (int e = 1; e <= 30; e++) begin
      if (e <= 5) in_two = ~in_two;
      tick();
      n = 0;
      for (int t = 22; t <= 25; t++) if (e >= t) n++;
      checks++;
      if (out_two !== n[0]) begin
        fails++;
        $display("[TB] FAIL overflow_out edge %0d: got %b expected %b", e, out_two, n[0]);
      end
      checks++;
      if (ovf_two !== (e >= 5)) begin
        fails++;
        $display("[TB] FAIL overflow_ovf edge %0d: got %b expected %b", e, ovf_two, (e >= 5));
      end
    end
    checks++;
    if (busy_two !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overflow_busy_end: got %b expected 0", busy_two);
    end
  endtask

  // Long delay first, short delay second: order is kept, B fires at 13.
  task automatic test_ordering;
    logic exp_out;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      if (e == 1) begin dly = 8'd10; in_two = 1'b1; end
      if (e == 2) begin dly = 8'd1;  in_two = 1'b0; end
      tick();
      exp_out = (e >= 12) ^ (e >= 13);
      checks++;
      if (out_two !== exp_out) begin
        fails++;
        $display("[TB] FAIL ordering_out edge %0d: got %b expected %b", e, out_two, exp_out);
      end
      checks++;
      if (busy_two !== (e <= 12)) begin
        fails++;
        $display("[TB] FAIL ordering_busy edge %0d: got %b expected %b", e, busy_two, (e <= 12));
      end
    end
  endtask

  // Full queue with a pop on the same edge accepts the new event.
  task automatic test_back_to_back;
    int n;
    do_reset();
    dly = 8'd3;
    for (int e = 1; e <= 12; e++) begin
      if (e <= 5) in_two = ~in_two;
      tick();
      n = 0;
      for (int t = 5; t <= 9; t++) if (e >= t) n++;
      checks++;
      if (out_two !== n[0]) begin
        fails++;
        $display("[TB] FAIL full_push_pop_out edge %0d: got %b expected %b", e, out_two, n[0]);
      end
      checks++;
      if (ovf_two !== 1'b0) begin
        fails++;
        $display("[TB] FAIL full_push_pop_ovf edge %0d: got %b expected 0", e, ovf_two);
      end
    end
  endtask

  // inR already high at reset release counts as an event in two-phase mode.
  task automatic test_release_event;
    rst     = 1'b0;
    in_two  = 1'b1;
    in_four = 1'b0;
    dly     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if ({busy_two, out_two} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL release_event_edge1: got busy,out=%b expected 10", {busy_two, out_two});
    end
    tick();
    checks++;
    if ({busy_two, out_two} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL release_event_edge2: got busy,out=%b expected 01", {busy_two, out_two});
    end
  endtask

  // Four-phase: rise at edge 3 held for 5 cycles gives one pulse at edge 6.
  task automatic test_four_phase;
    do_reset();
    dly = 8'd2;
    for (int e = 1; e <= 12; e++) begin
      in_four = (e >= 3) && (e <= 7);
      tick();
      checks++;
      if (out_four !== (e == 6)) begin
        fails++;
        $display("[TB] FAIL four_phase_out edge %0d: got %b expected %b", e, out_four, (e == 6));
      end
      checks++;
      if (busy_four !== ((e >= 3) && (e <= 5))) begin
        fails++;
        $display("[TB] FAIL four_phase_busy edge %0d: got %b expected %b", e, busy_four,
                 ((e >= 3) && (e <= 5)));
      end
    end
  endtask

  // Reset in mid-flight clears everything at once and discards held events.
  task automatic test_mid_reset;
    do_reset();
    dly    = 8'd0;
    in_two = 1'b1;
    tick();
    tick();
    dly = 8'd20;
    for (int e = 3; e <= 7; e++) begin
      in_two = ~in_two;
      tick();
    end
    tick();
    checks++;
    if ({out_two, busy_two, ovf_two} !== 3'b111) begin
      fails++;
      $display("[TB] FAIL mid_reset_pre: got out,busy,ovf=%b expected 111", {out_two, busy_two, ovf_two});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_two, busy_two, ovf_two} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL mid_reset_async: got out,busy,ovf=%b expected 000", {out_two, busy_two, ovf_two});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if ({out_two, busy_two} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL mid_reset_quiet edge %0d: got out,busy=%b expected 00", e, {out_two, busy_two});
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    in_two  = 1'b0;
    in_four = 1'b0;
    dly     = 8'd0;
    test_reset();
    test_latency();
    test_zero_delay();
    test_overflow();
    test_ordering();
    test_back_to_back();
    test_release_event();
    test_four_phase();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
